// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC transmit path.
// Frame layout: {2'b00, power-down bits, sample[7:0], 4'b0000}, sent MSB first.
package dac_pkg;

    localparam int         FRAME_BITS = 16;
    localparam logic [1:0] PD_NORMAL  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SHIFT,
        GAP
    } dac_state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] pd,
                                                          input logic [7:0] sample);
        return {2'b00, pd, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/dac_serializer.sv
// Pops one sample per frame and shifts it out as a 16-bit cs/sclk/sdata frame.
// Latency: cs falls two cycles after leaving IDLE/GAP; cs low for 32*CLK_DIV cycles.
// Backpressure: pops only when enabled and data is present; dropping enable aborts the frame.
module dac_serializer
    import dac_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] fifo_dat,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic       busy,
    output logic       cs,
    output logic       sclk,
    output logic       sdata
);

    localparam int DIV_W = $clog2(2*CLK_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       BIT_LAST = 5'(FRAME_BITS - 1);

    dac_state_t            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] load_frame;
    logic [4:0]            bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [GAP_W-1:0]      gap_cnt;

    assign load_frame = build_frame(PD_NORMAL, fifo_dat);
    assign fifo_rd    = (state == POP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            busy    <= 1'b0;
            cs      <= 1'b1;
            sclk    <= 1'b1;
            sdata   <= 1'b0;
        end else if ((state == POP || state == LOAD || state == SHIFT) && !enable) begin
            // Abort: the popped sample is thrown away and the link parks in its idle levels.
            state   <= GAP;
            gap_cnt <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b1;
            sdata   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        state <= POP;
                        busy  <= 1'b1;
                    end
                end
                POP: state <= LOAD;
                LOAD: begin
                    shreg   <= load_frame;
                    sdata   <= load_frame[FRAME_BITS-1];
                    cs      <= 1'b0;
                    sclk    <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                            cs      <= 1'b1;
                            sclk    <= 1'b1;
                            sdata   <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg << 1;
                            sdata   <= shreg[FRAME_BITS-2];
                            sclk    <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        if (div_cnt == DIV_HALF)
                            sclk <= 1'b0;
                    end
                end
                GAP: begin
                    // Skip IDLE when more data is waiting so frames stay back to back.
                    if (gap_cnt == GAP_LAST) begin
                        if (enable && !fifo_empty) begin
                            state <= POP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO with registered read data and asynchronous reset.
// Latency: rd_dat is valid the cycle after rd_en; full/empty update the cycle after the write/pop.
// Backpressure: writes while full are dropped, even if a pop happens in the same cycle.
module fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    // Full is sampled before this cycle's pop, so a write into a full buffer is lost.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_dat <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_dat <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dac_controller.sv
// Four-channel sample buffer feeding a 3-wire serial DAC; one channel selected by DAC_config[2:1].
// Latency: accepted write at edge T drives cs low at edge T+3 when idle and enabled.
// Backpressure: per-channel full flags (unselected channels read full); writes while full are dropped.
module dac_controller
    import dac_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] DAC_config,
    input  logic       DAC_write_en_0,
    input  logic       DAC_write_en_1,
    input  logic       DAC_write_en_2,
    input  logic       DAC_write_en_3,
    input  logic [7:0] DAC_data_0,
    input  logic [7:0] DAC_data_1,
    input  logic [7:0] DAC_data_2,
    input  logic [7:0] DAC_data_3,
    output logic       DAC_fifo_full_0,
    output logic       DAC_fifo_full_1,
    output logic       DAC_fifo_full_2,
    output logic       DAC_fifo_full_3,
    output logic       busy,
    output logic       cs,
    output logic       sclk,
    output logic       sdata
);

    logic [1:0] sel;
    logic       wr_en;
    logic [7:0] wr_dat;
    logic       fifo_rd;
    logic [7:0] fifo_dat;
    logic       fifo_full;
    logic       fifo_empty;
    logic       cfg_unused;

    assign sel        = DAC_config[2:1];
    assign cfg_unused = ^DAC_config[7:3];

    always_comb begin
        wr_en  = 1'b0;
        wr_dat = DAC_data_0;
        case (sel)
            2'd0: begin wr_en = DAC_write_en_0; wr_dat = DAC_data_0; end
            2'd1: begin wr_en = DAC_write_en_1; wr_dat = DAC_data_1; end
            2'd2: begin wr_en = DAC_write_en_2; wr_dat = DAC_data_2; end
            default: begin wr_en = DAC_write_en_3; wr_dat = DAC_data_3; end
        endcase
    end

    // Unselected channels see a permanently full buffer so their writers hold off.
    assign DAC_fifo_full_0 = (sel == 2'd0) ? fifo_full : 1'b1;
    assign DAC_fifo_full_1 = (sel == 2'd1) ? fifo_full : 1'b1;
    assign DAC_fifo_full_2 = (sel == 2'd2) ? fifo_full : 1'b1;
    assign DAC_fifo_full_3 = (sel == 2'd3) ? fifo_full : 1'b1;

    fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_dat (wr_dat),
        .rd_en  (fifo_rd),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    dac_serializer #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .enable     (DAC_config[0]),
        .fifo_dat   (fifo_dat),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .busy       (busy),
        .cs         (cs),
        .sclk       (sclk),
        .sdata      (sdata)
    );

endmodule

// File: tb/tb_dac_controller.sv
// Directed bench for dac_controller: a pin monitor decodes frames, directed vectors check them.
module tb_dac_controller;

    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 2;
    localparam int PERIOD     = 32*CLK_DIV + GAP_CYCLES + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg;
    logic [3:0] we;
    logic [7:0] dat [4];
    logic [3:0] full;
    logic       busy, cs, sclk, sdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_wr  = 0;

    // Monitor state and decoded frames
    logic        in_frame = 1'b0;
    logic        m_prev_sclk = 1'b1;
    logic [15:0] m_bits;
    int          m_nb, m_len, m_start, m_ff;
    logic [15:0] q_word  [$];
    int          q_nb    [$];
    int          q_len   [$];
    int          q_start [$];
    int          q_ff    [$];

    dac_controller #(
        .FIFO_DEPTH (16),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .DAC_config      (cfg),
        .DAC_write_en_0  (we[0]),
        .DAC_write_en_1  (we[1]),
        .DAC_write_en_2  (we[2]),
        .DAC_write_en_3  (we[3]),
        .DAC_data_0      (dat[0]),
        .DAC_data_1      (dat[1]),
        .DAC_data_2      (dat[2]),
        .DAC_data_3      (dat[3]),
        .DAC_fifo_full_0 (full[0]),
        .DAC_fifo_full_1 (full[1]),
        .DAC_fifo_full_2 (full[2]),
        .DAC_fifo_full_3 (full[3]),
        .busy            (busy),
        .cs              (cs),
        .sclk            (sclk),
        .sdata           (sdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && !cs) begin
                in_frame = 1'b1;
                m_bits   = '0;
                m_nb     = 0;
                m_len    = 0;
                m_start  = cyc;
                m_ff     = -1;
            end
            if (in_frame) begin
                if (!cs) begin
                    m_len++;
                    if (m_prev_sclk && !sclk) begin
                        m_bits = {m_bits[14:0], sdata};
                        if (m_nb == 0) m_ff = cyc;
                        m_nb++;
                    end
                end else begin
                    q_word.push_back(m_bits);
                    q_nb.push_back(m_nb);
                    q_len.push_back(m_len);
                    q_start.push_back(m_start);
                    q_ff.push_back(m_ff);
                    in_frame = 1'b0;
                end
            end
        end
        m_prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int ch, input logic [7:0] d);
        we[ch]  = 1'b1;
        dat[ch] = d;
        tick();
        we[ch]  = 1'b0;
        last_wr = cyc;
    endtask

    task automatic clear_q();
        q_word.delete(); q_nb.delete(); q_len.delete(); q_start.delete(); q_ff.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (q_word.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_frame_count"}, q_word.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, {31'b0, busy}, 0);
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] s);
        return {4'h0, s, 4'h0};
    endfunction

    initial begin
        logic [7:0] s;
        int falls;
        int k;
        logic prev;

        rst = 1'b1; cfg = 8'h00; we = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        repeat (3) tick();

        // Reset values
        check("rst_cs", {31'b0, cs}, 1);
        check("rst_sclk", {31'b0, sclk}, 1);
        check("rst_sdata", {31'b0, sdata}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_full", {28'b0, full}, 32'h0000_000e);
        rst = 1'b0;
        tick();

        // Single sample
        cfg = 8'h01;
        write(0, 8'hA5);
        wait_frames(1, 200, "single");
        check("single_word", {16'b0, q_word[0]}, 32'h0000_0a50);
        check("single_bits", q_nb[0], 16);
        check("single_cs_low", q_len[0], 64);
        check("single_cs_delay", q_start[0] - last_wr, 3);
        check("single_first_fall", q_ff[0] - q_start[0], CLK_DIV);
        wait_idle("single");
        clear_q();

        // Channel select: only ch2 is heard
        cfg = 8'h05;
        we[0] = 1'b1; dat[0] = 8'h3C;
        we[2] = 1'b1; dat[2] = 8'hC3;
        tick();
        we = '0;
        check("chsel_full", {28'b0, full}, 32'h0000_000b);
        wait_frames(1, 200, "chsel");
        check("chsel_word", {16'b0, q_word[0]}, 32'h0000_0c30);
        repeat (100) tick();
        check("chsel_no_extra", q_word.size(), 1);
        clear_q();

        // Fill while disabled, overflow, then drain
        cfg = 8'h04;
        for (int i = 1; i <= 17; i++) begin
            write(2, 8'(i));
            if (i == 15) check("fill_not_full15", {31'b0, full[2]}, 0);
            if (i == 16) check("fill_full16", {31'b0, full[2]}, 1);
            if (i == 17) check("fill_full17", {31'b0, full[2]}, 1);
        end
        check("fill_idle_disabled", {31'b0, busy}, 0);
        cfg = 8'h05;
        tick();
        check("drain_full_at_pop", {31'b0, full[2]}, 1);
        tick();
        check("drain_full_after_pop", {31'b0, full[2]}, 0);
        wait_frames(16, 16*PERIOD + 200, "drain");
        for (int i = 0; i < 16; i++) begin
            s = 8'(i + 1);
            check($sformatf("drain_word%0d", i), {16'b0, q_word[i]}, {16'b0, frame_of(s)});
            if (i > 0) check($sformatf("drain_period%0d", i), q_start[i] - q_start[i-1], PERIOD);
        end
        wait_idle("drain");
        repeat (150) tick();
        check("drain_17th_dropped", q_word.size(), 16);
        clear_q();

        // Abort at the 5th falling sclk edge
        cfg = 8'h04;
        write(2, 8'h11);
        write(2, 8'h22);
        write(2, 8'h33);
        cfg = 8'h05;
        falls = 0;
        k = 0;
        prev = sclk;
        while (falls < 5 && k < 300) begin
            tick();
            k++;
            if (!cs && prev && !sclk) falls++;
            prev = sclk;
        end
        check("abort_reached_fall5", falls, 5);
        cfg = 8'h04;
        tick();
        check("abort_cs", {31'b0, cs}, 1);
        check("abort_sclk", {31'b0, sclk}, 1);
        check("abort_sdata", {31'b0, sdata}, 0);
        tick();
        check("abort_bits", q_nb[0], 5);
        wait_idle("abort");
        cfg = 8'h05;
        wait_frames(3, 3*PERIOD + 200, "abort");
        check("abort_next0", {16'b0, q_word[1]}, {16'b0, frame_of(8'h22)});
        check("abort_next1", {16'b0, q_word[2]}, {16'b0, frame_of(8'h33)});
        wait_idle("abort_end");
        repeat (150) tick();
        check("abort_no_resend", q_word.size(), 3);
        clear_q();

        // Write and pop in the same cycle
        cfg = 8'h04;
        write(2, 8'h41);
        write(2, 8'h42);
        write(2, 8'h43);
        cfg = 8'h05;
        tick();
        check("wrpop_busy", {31'b0, busy}, 1);
        write(2, 8'h44);
        check("wrpop_count", {27'b0, u_dut.u_fifo.count}, 3);
        wait_frames(4, 4*PERIOD + 200, "wrpop");
        for (int i = 0; i < 4; i++) begin
            s = 8'h41 + 8'(i);
            check($sformatf("wrpop_word%0d", i), {16'b0, q_word[i]}, {16'b0, frame_of(s)});
        end
        wait_idle("wrpop");
        clear_q();

        // Reset mid-frame
        cfg = 8'h05;
        write(2, 8'h77);
        write(2, 8'h78);
        k = 0;
        while (cs && k < 50) begin
            tick();
            k++;
        end
        check("rstmid_in_frame", {31'b0, cs}, 0);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("rstmid_cs", {31'b0, cs}, 1);
        check("rstmid_sclk", {31'b0, sclk}, 1);
        check("rstmid_sdata", {31'b0, sdata}, 0);
        check("rstmid_busy", {31'b0, busy}, 0);
        tick();
        rst = 1'b0;
        check("rstmid_fifo_empty", {31'b0, u_dut.u_fifo.empty}, 1);
        repeat (150) tick();
        check("rstmid_no_frames", q_word.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_controller.md
# dac_controller

Transmit-side companion to the ADC capture path: buffers 8-bit samples written by one of four CPU-side channels and serialises each one as a 16-bit frame to an external serial DAC over a 3-wire link (`cs`, `sclk`, `sdata`). Channel selection and enable come from an 8-bit config register in the same format as the ADC side. The block sits between the register/bus logic and the DAC pins.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: sample buffer depth, power of two.
- `CLK_DIV`, 2: `clk` cycles per `sclk` half-period, ≥1.
- `GAP_CYCLES`, 2: `clk` cycles `cs` stays high between frames, ≥1.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `DAC_config`  in  8  [0] transmit enable; [2:1] active channel; [7:3] ignored.
- `DAC_write_en_0..3`  in  1 each  write strobe per channel.
- `DAC_data_0..3`  in  8 each  sample per channel.
- `DAC_fifo_full_0..3`  out  1 each  buffer full; reads 1 on unselected channels.
- `busy`  out  1  high from pop until the end of the frame gap.
- `cs`  out  1  DAC frame select, active low.
- `sclk`  out  1  serial clock, idles high.
- `sdata`  out  1  serial data, MSB first.

## Operation
- Write mux:
  - Only the channel selected by `DAC_config[2:1]` can write.
  - Strobes on unselected channels are ignored.
  - A write is accepted when the strobe is high and the FIFO is not full, regardless of `DAC_config[0]`.
  - A write while full is dropped, even if a pop happens in the same cycle.
- Simultaneous accepted write and pop: occupancy is unchanged and data order is preserved.
- Frame format, 16 bits: {2'b00, PD=2'b00 (normal mode), sample[7:0], 4'b0000}.
- FSM states: IDLE, POP, LOAD, SHIFT, GAP.
  - IDLE → POP: when `DAC_config[0]`=1 and the FIFO is not empty. POP asserts the FIFO read enable for one cycle.
  - POP → LOAD: unconditional. LOAD captures the FIFO output into a 16-bit shift register.
  - LOAD → SHIFT: unconditional.
  - SHIFT: 16 bits, each 2·`CLK_DIV` cycles long.
    - `sdata` = shift register MSB for the whole bit.
    - `sclk` is high for the first `CLK_DIV` cycles and low for the next `CLK_DIV` cycles. The DAC samples on the falling edge.
    - At the end of each bit the register shifts left. A 5-bit bit counter and a divider counter control this.
  - SHIFT → GAP: after the 16th bit's low phase.
  - GAP → IDLE: after `GAP_CYCLES` cycles. A new frame can start immediately if data is pending.
- Enable drop: if `DAC_config[0]` falls during POP, LOAD or SHIFT, the frame aborts.
  - Next cycle: `cs`=1, `sclk`=1, `sdata`=0, go to GAP.
  - The popped sample is discarded.
- Channel change mid-frame: does not affect the frame in flight. Full flags re-mux combinationally.
- `rst` at any time: FIFO empty, FSM in IDLE, counters cleared, any frame in flight abandoned.

## Timing
- Reset values: `cs`=1, `sclk`=1, `sdata`=0, `busy`=0. `DAC_fifo_full_k`=0 for the selected channel, 1 for the others.
- `cs`, `sclk` and `sdata` are registered outputs (no combinational path from inputs).
- Accepted write at edge T: FIFO non-empty from T+1, POP at T+1, LOAD at T+2, `cs` falls at T+3 (when IDLE and enabled).
- First falling `sclk` edge: `CLK_DIV` cycles after `cs` falls.
- `cs` is low for exactly 32·`CLK_DIV` cycles. `sclk` and `cs` return high on the same edge.
- Back-to-back frame period: 32·`CLK_DIV` + `GAP_CYCLES` + 2 cycles.
- Full flag asserts the cycle after the write that fills the buffer, and deasserts the cycle after the next pop.

## Structure
- Package `dac_pkg` holds:
  - `FRAME_BITS`=16, `PD_NORMAL`=2'b00;
  - FSM state enum;
  - a frame-build function {2'b00, PD, sample, 4'b0}.
- Buffer: the existing synchronous 8-bit `fifo` module (registered output, data valid the cycle after read enable), extended for async reset.
- One natural sub-module: `dac_serializer`, containing the FSM, divider, bit counter and shift register. Its interface is FIFO data, empty and read enable, plus `enable`, `busy`, `cs`, `sclk` and `sdata`.
- Write, full and channel muxes stay in the top level.

## Test plan
All scenarios use `CLK_DIV`=2 and `GAP_CYCLES`=2.
- Reset: assert `rst` mid-frame → `cs`=1, `sclk`=1, `sdata`=0 and `busy`=0 immediately (asynchronously); FIFO empty after release.
- Single sample: config=8'h01, write 8'hA5 on ch0 → `cs` low for 64 cycles, starting 3 cycles after the write; 16 falling edges sample 0000_1010_0101_0000.
- Channel select: config=8'h05, writes of 8'h3C on ch0 and 8'hC3 on ch2 in the same cycle → only 8'hC3 is framed; `DAC_fifo_full_0/1/3`=1.
- Full/overflow: config=8'h04 (disabled), 17 writes of 1..17 on ch2 → full after the 16th write, 17th dropped. Then enable → 16 frames carrying 1..16, each frame period 68 cycles.
- Abort: clear `DAC_config[0]` at the 5th falling edge → `cs` and `sclk` high next cycle; re-enable with data queued → the next frame carries the next sample, the aborted one is never resent.
- Write and pop in the same cycle with 3 entries queued → occupancy stays 3, output order matches write order.
